// File: rtl/safe_mode_seq_pkg.sv
// Shared types for the safe-mode reconfiguration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the applied-configuration record and its
// reset value. NCORES fixes the master one-hot width of safe_cfg_t.
package safe_mode_seq_pkg;

    localparam int NCORES = 3;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        WAIT_HALT,
        SYNC,
        WAIT_SYNC,
        APPLY,
        RESUME,
        WAIT_RUN
    } seq_state_e;

    typedef struct packed {
        logic [NCORES-1:0] master;
        logic              safe_mode;
        logic              safe_cfg;
    } safe_cfg_t;

    // Core 0 is master, safe mode off, default safe configuration.
    localparam safe_cfg_t SAFE_CFG_RST = '{master: NCORES'(1), safe_mode: 1'b0, safe_cfg: 1'b0};

endpackage

// File: rtl/safe_mode_seq_timer.sv
// Ack-wait timer: counts enabled cycles, saturates, flags expiry.
// Latency: count updates one cycle after clr_i/en_i; expired_o is combinational on the count.
// Backpressure: none; clr_i has priority over en_i.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         zero the count
//   en_i          advance the count (holds once expired)
//   expired_o     count has reached TimeoutCyc-1
module safe_mode_seq_timer #(
    parameter  int TimeoutCyc = 1024,
    localparam int TimeoutW   = $clog2(TimeoutCyc + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TimeoutW-1:0] r_cnt;
    logic                w_at_max;

    assign w_at_max  = (r_cnt == TimeoutW'(TimeoutCyc - 1));
    assign expired_o = w_at_max;

    // Stops at the expiry value so it never wraps back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_at_max) begin
            r_cnt <= r_cnt + TimeoutW'(1);
        end
    end

endmodule

// File: rtl/safe_mode_sequencer.sv
// Sequences safe-mode reconfiguration: halt cores, optional master sync, apply, resume.
// Latency: 6 cycles accept-to-done_o with immediate acks and no sync; 1 cycle for reject/no-op.
// Backpressure: req_ready_o is low whenever a sequence is in flight (state != IDLE).
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           request handshake; fields captured on accept
//   req_master_i/safe_mode_i/cfg_i    requested configuration (master one-hot)
//   halt_req_o/halted_i               per-core halt request and halted ack
//   sync_req_o/sync_done_i            master context-copy request and done pulse
//   master_core_o/safe_mode_o/cfg_o   applied configuration into the datapath
//   busy_o, done_o, err_o             status; done_o/err_o are one-cycle pulses
module safe_mode_sequencer
    import safe_mode_seq_pkg::*;
#(
    parameter int NCores     = 3,
    parameter int TimeoutCyc = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [NCores-1:0] req_master_i,
    input  logic              req_safe_mode_i,
    input  logic              req_safe_cfg_i,
    output logic [NCores-1:0] halt_req_o,
    input  logic [NCores-1:0] halted_i,
    output logic              sync_req_o,
    input  logic              sync_done_i,
    output logic [NCores-1:0] master_core_o,
    output logic              safe_mode_o,
    output logic              safe_cfg_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // The applied-config record is sized by the package core count.
    if (NCores != NCORES) begin : g_bad_ncores
        $error("safe_mode_sequencer: NCores must equal safe_mode_seq_pkg::NCORES");
    end

    seq_state_e        r_state;
    safe_cfg_t         r_applied;
    safe_cfg_t         r_req;
    logic              r_abort;
    logic [NCores-1:0] r_halt_req;
    logic              r_sync_req;
    logic              r_done;
    logic              r_err;

    safe_cfg_t w_req_cfg;
    logic      w_tmr_clr;
    logic      w_tmr_en;
    logic      w_tmr_expired;
    logic      w_all_halted;
    logic      w_all_running;

    assign w_req_cfg     = '{master: req_master_i, safe_mode: req_safe_mode_i, safe_cfg: req_safe_cfg_i};
    assign w_all_halted  = &halted_i;
    assign w_all_running = (halted_i == '0);

    // Timer runs only in the wait states; every other state holds it at zero,
    // so each wait starts counting from zero on entry.
    assign w_tmr_en  = (r_state == WAIT_HALT) || (r_state == WAIT_SYNC) || (r_state == WAIT_RUN);
    assign w_tmr_clr = !w_tmr_en;

    safe_mode_seq_timer #(
        .TimeoutCyc (TimeoutCyc)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_tmr_clr),
        .en_i      (w_tmr_en),
        .expired_o (w_tmr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_applied  <= SAFE_CFG_RST;
            r_req      <= SAFE_CFG_RST;
            r_abort    <= 1'b0;
            r_halt_req <= '0;
            r_sync_req <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (!$onehot(req_master_i)) begin
                            r_err <= 1'b1;
                        end else if (w_req_cfg == r_applied) begin
                            // Nothing to change: skip the halt entirely.
                            r_done <= 1'b1;
                        end else begin
                            r_req      <= w_req_cfg;
                            r_abort    <= 1'b0;
                            r_halt_req <= '1;
                            r_state    <= HALT;
                        end
                    end
                end
                HALT: begin
                    r_state <= WAIT_HALT;
                end
                WAIT_HALT: begin
                    // An ack on the expiry cycle wins over the abort.
                    if (w_all_halted) begin
                        if (r_req.safe_mode && !r_applied.safe_mode) begin
                            r_sync_req <= 1'b1;
                            r_state    <= SYNC;
                        end else begin
                            r_state <= APPLY;
                        end
                    end else if (w_tmr_expired) begin
                        r_abort    <= 1'b1;
                        r_halt_req <= '0;
                        r_state    <= RESUME;
                    end
                end
                SYNC: begin
                    r_state <= WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    if (sync_done_i) begin
                        r_sync_req <= 1'b0;
                        r_state    <= APPLY;
                    end else if (w_tmr_expired) begin
                        r_abort    <= 1'b1;
                        r_sync_req <= 1'b0;
                        r_halt_req <= '0;
                        r_state    <= RESUME;
                    end
                end
                APPLY: begin
                    r_applied  <= r_req;
                    r_halt_req <= '0;
                    r_state    <= RESUME;
                end
                RESUME: begin
                    r_state <= WAIT_RUN;
                end
                WAIT_RUN: begin
                    // An earlier abort is reported only once the cores run again.
                    if (w_all_running) begin
                        r_done  <= !r_abort;
                        r_err   <= r_abort;
                        r_state <= IDLE;
                    end else if (w_tmr_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign halt_req_o    = r_halt_req;
    assign sync_req_o    = r_sync_req;
    assign master_core_o = r_applied.master;
    assign safe_mode_o   = r_applied.safe_mode;
    assign safe_cfg_o    = r_applied.safe_cfg;
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// Directed bench for safe_mode_sequencer with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_safe_mode_sequencer;

    localparam int NC  = 3;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NC-1:0] req_master = 3'b001;
    logic          req_mode = 1'b0;
    logic          req_cfg = 1'b0;
    logic [NC-1:0] halt_req;
    logic [NC-1:0] halted;
    logic          sync_req;
    logic          sync_done = 1'b0;
    logic [NC-1:0] master_core;
    logic          safe_mode;
    logic          safe_cfg;
    logic          busy;
    logic          done;
    logic          err;

    // Core model: either acks halts immediately or holds a forced pattern.
    logic          ack_auto = 1'b1;
    logic [NC-1:0] halted_frc = 3'b000;
    assign halted = ack_auto ? halt_req : halted_frc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    safe_mode_sequencer #(
        .NCores     (NC),
        .TimeoutCyc (TMO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_master_i    (req_master),
        .req_safe_mode_i (req_mode),
        .req_safe_cfg_i  (req_cfg),
        .halt_req_o      (halt_req),
        .halted_i        (halted),
        .sync_req_o      (sync_req),
        .sync_done_i     (sync_done),
        .master_core_o   (master_core),
        .safe_mode_o     (safe_mode),
        .safe_cfg_o      (safe_cfg),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ck1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ck3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ck_applied(input string tag, input logic [2:0] m, input logic md, input logic c);
        ck3({tag, ".master"}, master_core, m);
        ck1({tag, ".mode"}, safe_mode, md);
        ck1({tag, ".cfg"}, safe_cfg, c);
    endtask

    task automatic ck_reset_state(input string tag);
        ck_applied(tag, 3'b001, 1'b0, 1'b0);
        ck3({tag, ".halt"}, halt_req, 3'b000);
        ck1({tag, ".sync"}, sync_req, 1'b0);
        ck1({tag, ".busy"}, busy, 1'b0);
        ck1({tag, ".done"}, done, 1'b0);
        ck1({tag, ".err"}, err, 1'b0);
        ck1({tag, ".ready"}, req_ready, 1'b1);
    endtask

    // Present a request for one cycle; returns in the cycle after acceptance.
    task automatic send(input logic [2:0] m, input logic md, input logic c);
        req_master = m;
        req_mode   = md;
        req_cfg    = c;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        tick();
        ck_reset_state("rst");

        // Request identical to reset config: done next cycle, no halt
        send(3'b001, 1'b0, 1'b0);
        ck1("noop.done", done, 1'b1);
        ck3("noop.halt", halt_req, 3'b000);
        ck1("noop.busy", busy, 1'b0);
        tick();
        ck1("noop.done_clr", done, 1'b0);
        ck3("noop.halt2", halt_req, 3'b000);

        // Safe mode 0->1 with master sync
        send(3'b001, 1'b1, 1'b0);
        ck3("s1.halt_req", halt_req, 3'b111);
        ck1("s1.busy", busy, 1'b1);
        ck1("s1.ready", req_ready, 1'b0);
        tick();                                   // WAIT_HALT
        ck1("s1.no_sync_yet", sync_req, 1'b0);
        tick();                                   // SYNC
        ck1("s1.sync_req", sync_req, 1'b1);
        tick();                                   // WAIT_SYNC, 1st cycle
        ck1("s1.sync_hold", sync_req, 1'b1);
        ck1("s1.mode_old", safe_mode, 1'b0);
        tick();                                   // WAIT_SYNC, 2nd cycle
        sync_done = 1'b1;
        tick();                                   // APPLY
        sync_done = 1'b0;
        ck1("s1.sync_drop", sync_req, 1'b0);
        ck1("s1.mode_pre_apply", safe_mode, 1'b0);
        ck3("s1.halt_apply", halt_req, 3'b111);
        tick();                                   // RESUME
        ck_applied("s1.applied", 3'b001, 1'b1, 1'b0);
        ck3("s1.halt_rel", halt_req, 3'b000);
        tick();                                   // WAIT_RUN
        ck1("s1.done_early", done, 1'b0);
        tick();                                   // IDLE
        ck1("s1.done", done, 1'b1);
        ck1("s1.err", err, 1'b0);
        ck1("s1.busy_low", busy, 1'b0);
        tick();
        ck1("s1.done_clr", done, 1'b0);

        // Illegal masters
        send(3'b011, 1'b0, 1'b1);
        ck1("ill.err", err, 1'b1);
        ck1("ill.ready", req_ready, 1'b1);
        ck1("ill.busy", busy, 1'b0);
        ck3("ill.halt", halt_req, 3'b000);
        ck_applied("ill.applied", 3'b001, 1'b1, 1'b0);
        tick();
        ck1("ill.err_clr", err, 1'b0);
        send(3'b000, 1'b1, 1'b1);
        ck1("ill0.err", err, 1'b1);
        ck1("ill0.done", done, 1'b0);
        tick();

        // Halt ack never complete (110): abort, old config kept
        ack_auto   = 1'b0;
        halted_frc = 3'b110;
        send(3'b010, 1'b1, 1'b1);                 // HALT
        tick();                                   // WAIT_HALT, timer 0
        repeat (TMO - 1) tick();                  // timer at TMO-1
        ck3("to.halt_held", halt_req, 3'b111);
        ck1("to.busy", busy, 1'b1);
        ck1("to.err_early", err, 1'b0);
        tick();                                   // RESUME after abort
        ck3("to.halt_rel", halt_req, 3'b000);
        ck_applied("to.kept", 3'b001, 1'b1, 1'b0);
        halted_frc = 3'b000;
        tick();                                   // WAIT_RUN
        ck1("to.err_wait", err, 1'b0);
        tick();                                   // IDLE
        ck1("to.err", err, 1'b1);
        ck1("to.done", done, 1'b0);
        ck1("to.busy_low", busy, 1'b0);
        ck_applied("to.kept2", 3'b001, 1'b1, 1'b0);
        tick();

        // Halt ack arrives exactly on the expiry cycle: success
        halted_frc = 3'b000;
        send(3'b100, 1'b1, 1'b1);                 // HALT
        tick();                                   // WAIT_HALT, timer 0
        repeat (TMO - 1) tick();                  // timer at TMO-1
        halted_frc = 3'b111;
        tick();                                   // APPLY
        ck3("edge.halt_held", halt_req, 3'b111);
        ck1("edge.busy", busy, 1'b1);
        ack_auto = 1'b1;
        tick();                                   // RESUME
        ck_applied("edge.applied", 3'b100, 1'b1, 1'b1);
        tick();                                   // WAIT_RUN
        tick();                                   // IDLE
        ck1("edge.done", done, 1'b1);
        ck1("edge.err", err, 1'b0);
        tick();

        // Six-cycle latency with immediate acks, no sync (mode 1->0)
        send(3'b100, 1'b0, 1'b1);
        repeat (4) tick();
        ck1("lat.done_c5", done, 1'b0);
        tick();
        ck1("lat.done_c6", done, 1'b1);
        ck_applied("lat.applied", 3'b100, 1'b0, 1'b1);
        tick();

        // Reset while waiting for the sync
        send(3'b010, 1'b1, 1'b0);                 // HALT
        tick();                                   // WAIT_HALT
        tick();                                   // SYNC
        tick();                                   // WAIT_SYNC
        ck1("mr.sync_req", sync_req, 1'b1);
        ck1("mr.busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        ck_reset_state("mr");
        rst = 1'b0;
        tick();
        ck1("mr.idle_busy", busy, 1'b0);
        ck1("mr.idle_ready", req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
